// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard unit for a five-stage pipeline with a blocking data cache.
// Produces stall/flush/forward controls and halts the pipe if a cache miss never resolves.
// Optional feature macro: HAZ_STALL_CNT_EN adds the StallCount port and its counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              CacheReady,
  input  logic              MemReqM,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MissTimeout
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCount
`endif
);

  typedef enum logic [1:0] {RUN, MISS, HALT} state_t;

  // The counter value seen on the last MISS cycle allowed before giving up.
  localparam logic [15:0] TIMEOUT_LAST = 16'(MISS_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic        miss;
  logic        load_use;

  assign miss     = MemReqM & ~CacheReady;
  assign load_use = MemtoRegE & RegWriteE & (WriteRegE != '0) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD));

  // Next-state and stall/flush decode; a miss outranks a branch, which outranks load-use.
  always_comb begin
    next_state = state;
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    case (state)
      RUN: begin
        if (miss) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW     = 1'b1;
          next_state = MISS;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MISS: begin
        if (!CacheReady) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW = 1'b1;
          if (wait_cnt >= TIMEOUT_LAST) next_state = HALT;
        end else begin
          next_state = RUN;
        end
      end
      HALT: begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        FlushW = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  // State register plus the miss wait counter and the sticky timeout flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      MissTimeout <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN && next_state == MISS) begin
        wait_cnt <= '0;
      end else if (state == MISS && !CacheReady && wait_cnt != 16'hFFFF) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (next_state == HALT) MissTimeout <= 1'b1;
    end
  end

  // Forwarding selects, computed in every state; the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && WriteRegM != '0 && WriteRegM == RsE)      ForwardAE = 2'b10;
    else if (RegWriteW && WriteRegW != '0 && WriteRegW == RsE) ForwardAE = 2'b01;
    if (RegWriteM && WriteRegM != '0 && WriteRegM == RtE)      ForwardBE = 2'b10;
    else if (RegWriteW && WriteRegW != '0 && WriteRegW == RtE) ForwardBE = 2'b01;
  end

`ifdef HAZ_STALL_CNT_EN
  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
    end else if (StallF && StallCount != '1) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`else
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width in bits.
REQ-002 Parameter MISS_TIMEOUT, default 255: maximum MISS cycles before HALT, legal range 1..2^16-1.
REQ-003 Parameter CNT_W, default 32: stall-counter width, used only when HAZ_STALL_CNT_EN is defined.
REQ-004 Clock and reset SHALL be a single clock, CLK, and an asynchronous active-low reset, reset.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 CacheReady  in  1  data cache has completed the M-stage access.
REQ-008 MemReqM  in  1  M-stage instruction is a load or a store.
REQ-009 RsD, RtD, RsE, RtE  in  REG_AW  source register numbers in D and E.
REQ-010 WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register numbers in E, M and W.
REQ-011 RegWriteE, RegWriteM, RegWriteW  in  1  destination is written.
REQ-012 MemtoRegE  in  1  E-stage instruction is a load.
REQ-013 PCSrcE  in  1  branch resolved as taken in E.
REQ-014 StallF, StallD, StallE, StallM  out  1  hold the stage register.
REQ-015 FlushD, FlushE, FlushM, FlushW  out  1  bubble the stage register.
REQ-016 ForwardAE, ForwardBE  out  2  forwarding selects: 00 = register file, 10 = M stage, 01 = W stage.
REQ-017 MissTimeout  out  1  sticky flag: HALT has been entered.
REQ-018 StallCount  out  CNT_W  stall-cycle count; present only when HAZ_STALL_CNT_EN is defined.

Function
REQ-019 Control FSM states: RUN, MISS, HALT.
REQ-020 Stall and flush outputs are combinational from the current state and the inputs, with zero-cycle latency.
REQ-021 Miss condition: MemReqM=1 and CacheReady=0.
REQ-022 RUN with the miss condition: StallF/D/E/M=1, FlushW=1, and the FSM moves to MISS.
REQ-023 MISS with CacheReady=0: StallF/D/E/M=1 and FlushW=1; the wait counter increments.
REQ-024 MISS with CacheReady=1: no stalls in that cycle, and the FSM moves to RUN on the next edge.
REQ-025 The wait counter is 16 bits, clears on entry to MISS, and saturates rather than wraps.
REQ-026 When the wait counter reaches MISS_TIMEOUT with CacheReady=0, the FSM moves to HALT and MissTimeout is set.
REQ-027 HALT: StallF/D/E/M=1 and FlushW=1 permanently; only reset exits HALT.
REQ-028 Load-use hazard: MemtoRegE=1, RegWriteE=1, WriteRegE≠0, and WriteRegE equals RsD or RtD.
REQ-029 In RUN with no miss, a load-use hazard gives StallF=1, StallD=1, FlushE=1.
REQ-030 In RUN with no miss, PCSrcE=1 gives FlushD=1 and FlushE=1, and suppresses StallF and StallD.
REQ-031 Priority order: HALT, then miss or MISS, then branch, then load-use.
REQ-032 In MISS and HALT, FlushD and FlushE are 0; a held PCSrcE takes effect on the first RUN cycle.
REQ-033 FlushM is 0 in all states; it is reserved for future use.
REQ-034 ForwardAE is 10 when RegWriteM=1, WriteRegM≠0 and WriteRegM=RsE.
REQ-035 Otherwise ForwardAE is 01 when RegWriteW=1, WriteRegW≠0 and WriteRegW=RsE; otherwise 00.
REQ-036 ForwardBE follows the same rules as ForwardAE using RtE.
REQ-037 Forwarding outputs are computed in every state, and the M stage takes priority over W.

Reset
REQ-038 While reset=0: FSM in RUN, wait counter 0, MissTimeout 0, StallCount 0.
REQ-039 Reset asserted in MISS or HALT returns the FSM to RUN immediately, without waiting for a clock edge.
REQ-040 Stall, flush and forward outputs follow REQ-020 to REQ-037 evaluated in RUN during reset.

Configuration
REQ-041 Macro HAZ_STALL_CNT_EN defined: StallCount increments each cycle in which StallF=1, saturating at 2^CNT_W-1.
REQ-042 Macro HAZ_STALL_CNT_EN undefined: the StallCount port and its counter are absent; all other behaviour is identical.

Verification
REQ-043 RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-044 MemtoRegE=1, RegWriteE=1, WriteRegE=3, RtD=3, in RUN -> StallF=1, StallD=1, FlushE=1 for one cycle.
REQ-045 Load-use hazard and PCSrcE=1 in the same cycle -> FlushD=1, FlushE=1, StallF=0, StallD=0.
REQ-046 MemReqM=1, CacheReady low for 4 cycles then high -> StallF..M and FlushW high 4 cycles, back in RUN after edge 5.
REQ-047 MISS_TIMEOUT=8, CacheReady held low -> HALT and MissTimeout=1 after 8 MISS cycles; reset=0 mid-HALT -> RUN, MissTimeout=0.
REQ-048 With HAZ_STALL_CNT_EN defined, the REQ-046 sequence followed by the REQ-044 hazard -> StallCount=5.
